// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: status encodings, display
// limits, active-low 7-segment patterns and small BCD helpers.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    localparam logic [7:0] MAX_MIN = 8'd99;
    localparam logic [5:0] MAX_SEC = 6'd59;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_phase_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// Sequential shift-add-3 converter for values 0..99; done pulses 9 cycles
// after an accepted start, with tens/units valid from that cycle on.
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [15:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] adj_s;

    // Next-state: load on start when idle, otherwise one add-3/shift per cycle
    always_comb begin
        adj_s  = {add3(sh_q[15:12]), add3(sh_q[11:8]), sh_q[7:0]};
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            sh_d  = {adj_s[14:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start) begin
            sh_d   = {8'h00, bin};
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else begin
            sh_d = sh_q;
        end
    end

    // Converter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= 16'h0000;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign tens  = sh_q[15:12];
    assign units = sh_q[11:8];

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed MM:SS common-anode display driver: snapshots inputs once per
// frame, converts to BCD, scans four digits and blinks while paused.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam logic [15:0] DIV_LAST   = 16'(REFRESH_DIV - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic               run_q, run_d;
    logic [15:0]        div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         status_q, status_d;
    blink_phase_e       phase_q, phase_d;
    logic [7:0]         bcnt_q, bcnt_d;
    logic [3:0][3:0]    dig_q, dig_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               fs_q, fs_d;

    logic               fs_s, visible_s, conv_start_s;
    logic [7:0]         min_sat_s, sec_sat_s;
    logic               min_busy_s, min_done_s, sec_busy_s, sec_done_s;
    logic [3:0]         min_tens_s, min_units_s, sec_tens_s, sec_units_s;

    assign min_sat_s    = (minutes > MAX_MIN) ? MAX_MIN : minutes;
    assign sec_sat_s    = {2'b00, (seconds > MAX_SEC) ? MAX_SEC : seconds};
    assign conv_start_s = fs_s && !(min_busy_s || sec_busy_s);

    bin2bcd_seq u_min_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (min_sat_s),
        .busy  (min_busy_s),
        .done  (min_done_s),
        .tens  (min_tens_s),
        .units (min_units_s)
    );

    bin2bcd_seq u_sec_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (sec_sat_s),
        .busy  (sec_busy_s),
        .done  (sec_done_s),
        .tens  (sec_tens_s),
        .units (sec_units_s)
    );

    // Scan timing, frame snapshot, blink phase and registered display outputs
    always_comb begin
        // run_q holds off the scan for one cycle so the first lit digit follows a frame start
        fs_s     = run_q && (idx_q == 2'd3) && (div_q == 16'd0);
        run_d    = 1'b1;
        status_d = status_q;
        phase_d  = phase_q;
        bcnt_d   = bcnt_q;
        dig_d    = dig_q;

        if (!run_q) begin
            div_d = 16'd0;
            idx_d = idx_q;
        end else if (div_q == DIV_LAST) begin
            div_d = 16'd0;
            idx_d = idx_q - 2'd1;
        end else begin
            div_d = div_q + 16'd1;
            idx_d = idx_q;
        end
        fs_d = (idx_d == 2'd3) && (div_d == 16'd0);

        if (fs_s) begin
            status_d = status;
            if (status != ST_PAUSE) begin
                phase_d = PH_VISIBLE;
                bcnt_d  = 8'd0;
            end else if (status_q != ST_PAUSE) begin
                bcnt_d = 8'd0;
            end else if (bcnt_q == BLINK_LAST) begin
                phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
                bcnt_d  = 8'd0;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end else begin
            status_d = status_q;
        end

        if (min_done_s) begin
            dig_d[3] = min_tens_s;
            dig_d[2] = min_units_s;
        end else begin
            dig_d[3] = dig_q[3];
            dig_d[2] = dig_q[2];
        end
        if (sec_done_s) begin
            dig_d[1] = sec_tens_s;
            dig_d[0] = sec_units_s;
        end else begin
            dig_d[1] = dig_q[1];
            dig_d[0] = dig_q[0];
        end

        // Uses the next phase so a blink change applies from the first digit of the frame
        visible_s = run_q && !((status_d == ST_PAUSE) && (phase_d == PH_HIDDEN));
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (visible_s) begin
            an_d[idx_q] = 1'b0;
            seg_d       = seg_decode(dig_q[idx_q]);
            dp_d        = (idx_q == 2'd2) ? 1'b0 : 1'b1;
        end else begin
            an_d  = 4'b1111;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // All display state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            div_q    <= 16'd0;
            idx_q    <= 2'd3;
            status_q <= ST_IDLE;
            phase_q  <= PH_VISIBLE;
            bcnt_q   <= 8'd0;
            dig_q    <= 16'h0000;
            an_q     <= 4'b1111;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            run_q    <= run_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            phase_q  <= phase_d;
            bcnt_q   <= bcnt_d;
            dig_q    <= dig_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            fs_q     <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with REFRESH_DIV=16, BLINK_FRAMES=2.
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S6 = 7'h02;
    localparam logic [6:0] S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F;

    always #5 clk = ~clk;

    stopwatch_display #(
        .REFRESH_DIV  (16),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .minutes     (minutes),
        .seconds     (seconds),
        .status      (status),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        check(tag, {15'd0, frame_start}, 16'd1);
    endtask

    // Called in cycle start_c of a frame (frame_start cycle is 0); digit d is lit
    // during cycles 1+16*(3-d) .. 16+16*(3-d); sample each at offset 12 into its slot.
    task automatic check_frame(input string tag, input logic [3:0][6:0] exp_seg,
                               input bit vis, input int start_c);
        int cur;
        int tgt;
        int d;
        cur = start_c;
        for (int p = 0; p < 4; p++) begin
            tgt = 13 + 16 * p;
            repeat (tgt - cur) @(negedge clk);
            cur = tgt;
            d = 3 - p;
            check({tag, "_an"},  {12'd0, an},  vis ? {12'd0, ~(4'b0001 << d)} : 16'h000F);
            check({tag, "_seg"}, {9'd0, seg},  vis ? {9'd0, exp_seg[d]} : {9'd0, SB});
            check({tag, "_dp"},  {15'd0, dp},  (vis && d == 2) ? 16'd0 : 16'd1);
        end
    endtask

    initial begin
        rst     = 1'b1;
        minutes = 8'd77;
        seconds = 6'd21;
        status  = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_an",  {12'd0, an},  16'h000F);
        check("rst_seg", {9'd0, seg},  16'h007F);
        check("rst_dp",  {15'd0, dp},  16'd1);
        check("rst_fs",  {15'd0, frame_start}, 16'd0);

        minutes = 8'd12;
        seconds = 6'd34;
        status  = 2'b01;
        rst     = 1'b0;
        @(negedge clk);
        check("rel_fs",   {15'd0, frame_start}, 16'd1);
        check("rel_dark", {12'd0, an}, 16'h000F);
        @(negedge clk);
        check("rel_an3",  {12'd0, an}, 16'h0007);
        check("rel_fs0",  {15'd0, frame_start}, 16'd0);

        wait_fs("fs_disp");
        check_frame("disp_1234", {S1, S2, S3, S4}, 1'b1, 0);

        minutes = 8'd200;
        seconds = 6'd63;
        wait_fs("fs_sat");
        check_frame("sat_9959", {S9, S9, S5, S9}, 1'b1, 0);

        minutes = 8'd0;
        seconds = 6'd0;
        wait_fs("fs_zero");
        check_frame("zero_0000", {S0, S0, S0, S0}, 1'b1, 0);

        minutes = 8'd12;
        seconds = 6'd34;
        wait_fs("fs_snap");
        @(negedge clk);
        seconds = 6'd35;
        check_frame("snap_old", {S1, S2, S3, S4}, 1'b1, 1);
        wait_fs("fs_snap_new");
        check_frame("snap_new", {S1, S2, S3, S5}, 1'b1, 0);

        status = 2'b10;
        wait_fs("fs_p1");
        check_frame("pause_v1", {S1, S2, S3, S5}, 1'b1, 0);
        wait_fs("fs_p2");
        check_frame("pause_v2", {S1, S2, S3, S5}, 1'b1, 0);
        wait_fs("fs_p3");
        check_frame("pause_h1", {S1, S2, S3, S5}, 1'b0, 0);
        status = 2'b01;
        wait_fs("fs_resume");
        check_frame("resume_vis", {S1, S2, S3, S5}, 1'b1, 0);

        wait_fs("fs_prerst");
        repeat (4) @(negedge clk);
        check("pre_rst_an", {12'd0, an}, 16'h0007);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_an",  {12'd0, an},  16'h000F);
        check("mid_rst_seg", {9'd0, seg},  16'h007F);
        check("mid_rst_dp",  {15'd0, dp},  16'd1);
        check("mid_rst_fs",  {15'd0, frame_start}, 16'd0);
        minutes = 8'd45;
        seconds = 6'd6;
        status  = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        wait_fs("fs_after_rst");
        check_frame("after_rst_4506", {S4, S5, S0, S6}, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
